serial_cmp_ctrl: RTL and testbench



---
 rtl/serial_cmp_ctrl.sv | 99 +++++++++
 tb/tb_serial_cmp_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_cmp_ctrl.sv
// Bit-serial magnitude comparator: MSB-first scan through one 1-bit slice, early exit.
// Ports: clk, reset(async hi), start, x, y -> busy, done, EQ, LT. Option: SERIAL_CMP_SIGNED_EN.
module serial_cmp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             EQ,
  output logic             LT
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] TOP = IW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] xr;
  logic [WIDTH-1:0] yr;
  logic [IW-1:0]    idx;
  logic             gt;
  logic             eq;
  logic             lt_dec;

  // The shared 1-bit slice: {gt, eq}.
  function automatic logic [1:0] cmp1(
    input logic a,
    input logic b
  );
    return {a & ~b, a ~^ b};
  endfunction

  always_comb begin
    {gt, eq} = cmp1(xr[idx], yr[idx]);
  end

  always_comb begin
    lt_dec = ~gt;
`ifdef SERIAL_CMP_SIGNED_EN
    // A differing sign bit flips the order.
    if (idx == TOP) begin
      lt_dec = gt;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      EQ    <= 1'b0;
      LT    <= 1'b0;
      xr    <= '0;
      yr    <= '0;
      idx   <= TOP;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            xr    <= x;
            yr    <= y;
            idx   <= TOP;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (!eq) begin
            EQ    <= 1'b0;
            LT    <= lt_dec;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (idx == '0) begin
            EQ    <= 1'b1;
            LT    <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Self-checking bench for serial_cmp_ctrl: directed cases then random ops vs a model.
// Model uses plain comparisons and first-differing-bit latency.
module tb_serial_cmp_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         busy;
  logic         done;
  logic         EQ;
  logic         LT;

  int checks = 0;
  int errors = 0;
  logic last_eq;
  logic last_lt;

  serial_cmp_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .EQ    (EQ),
    .LT    (LT)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    for (int i = W - 1; i >= 0; i--) begin
      if (a[i] !== b[i]) return W - i;
    end
    return W;
  endfunction

  function automatic logic exp_lt(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
`ifdef SERIAL_CMP_SIGNED_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  // Starts an op (from a point #1 after an edge) and waits for done.
  // poke=1 re-asserts start with other operands while busy.
  task automatic run_op(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input bit           poke,
    input string        tag
  );
    int n;
    int lat;
    lat = exp_lat(a, b);
    x = a;
    y = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = poke;
    x = W'($urandom);
    y = W'($urandom);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < W + 4) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 2) start = 1'b0;
      x = W'($urandom);
      y = W'($urandom);
    end
    start = 1'b0;
    last_eq = (a == b);
    last_lt = exp_lt(a, b);
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_eq"}, 32'(EQ), 32'(last_eq));
    check({tag, "_lt"}, 32'(LT), 32'(last_lt));
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // One idle edge: done must have dropped and the result must hold.
  task automatic idle_check(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_donelo"}, 32'(done), 32'd0);
    check({tag, "_eqhold"}, 32'(EQ), 32'(last_eq));
    check({tag, "_lthold"}, 32'(LT), 32'(last_lt));
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int mode;

    // Asynchronous reset between edges, no clock needed.
    #7 reset = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_eq", 32'(EQ), 32'd0);
    check("rst_lt", 32'(LT), 32'd0);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    check("rel_busy", 32'(busy), 32'd0);
    check("rel_done", 32'(done), 32'd0);

    // Directed cases.
    run_op(8'hA5, 8'h25, 1'b0, "a5_25");
    idle_check("a5_25");
    run_op(8'h3C, 8'h3C, 1'b0, "eq3c");
    idle_check("eq3c");
    run_op(8'h10, 8'h11, 1'b0, "b0diff");
    run_op(8'h80, 8'h7F, 1'b0, "b2b");
    idle_check("b2b");

    // Start while busy is ignored.
    run_op(8'h3C, 8'h3D, 1'b1, "poke");
    idle_check("poke");
    run_op(8'h12, 8'h13, 1'b1, "poke2");
    idle_check("poke2");

    // Reset in the middle of a long scan.
    run_op(8'h55, 8'h55, 1'b0, "pre");
    idle_check("pre");
    x = 8'h3C;
    y = 8'h3C;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_eq", 32'(EQ), 32'd0);
    check("mid_lt", 32'(LT), 32'd0);
    #1 reset = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (10) begin
        @(posedge clk);
        #1;
        if (done) seen++;
      end
      check("mid_nodone", 32'(seen), 32'd0);
    end
    last_eq = 1'b0;
    last_lt = 1'b0;
    idle_check("mid_hold");
    run_op(8'hC3, 8'hC1, 1'b0, "post");
    idle_check("post");

    // Random ops, biased toward long equal prefixes.
    for (int k = 0; k < 40; k++) begin
      a = W'($urandom);
      mode = $urandom_range(0, 2);
      if (mode == 0) b = W'($urandom);
      else if (mode == 1) b = a;
      else b = a ^ W'(1 << $urandom_range(0, W - 1));
      run_op(a, b, 1'b0, $sformatf("rnd%0d", k));
      if ($urandom_range(0, 1) == 0) begin
        idle_check($sformatf("rnd%0d", k));
      end
    end
    idle_check("last");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
